// File: rtl/sport_pkg.sv
// Shared SPORT0 types and constants for the transmit path and the clock generator.
package sport_pkg;

    localparam int unsigned TX_WIDTH = 32;
    localparam int unsigned SLEN_MIN = 1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SHIFT
    } state_e;

endpackage

// File: rtl/sport0_tx_serializer_if.sv
// Core-side TX buffer write port and status flags of the SPORT0 transmitter.
interface sport0_tx_serializer_if;
    import sport_pkg::*;

    logic [TX_WIDTH-1:0] TX_DATA;
    logic                TX_we;
    logic                TBUF_FULL;
    logic                TXREQ;
    logic                TUVF;

    modport master (output TX_DATA, TX_we, input TBUF_FULL, TXREQ, TUVF);
    modport slave  (input TX_DATA, TX_we, output TBUF_FULL, TXREQ, TUVF);

endinterface

// File: rtl/sport_sclk_gen.sv
// SPORT serial clock: internal divider or external SCLK, producing driving/sampling edge strobes.
module sport_sclk_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        isclk,
    input  logic [15:0] sclkdiv,
    input  logic        sclk_in,
    output logic        de,
    output logic        se,
    output logic        sclk_int
);

    logic [15:0] cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic        ext_q, ext_prev_q;
    logic        tick;

    always_comb begin
        tick   = isclk && (cnt_q == 16'd0);
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        de     = 1'b0;
        se     = 1'b0;
        if (!isclk) begin
            cnt_d  = sclkdiv;
            sclk_d = 1'b0;
            de     = en && ext_q && !ext_prev_q;
            se     = en && !ext_q && ext_prev_q;
        end else if (tick) begin
            cnt_d  = sclkdiv;
            sclk_d = ~sclk_q;
            // The edge that raises sclk_int is the driving edge
            de     = en && !sclk_q;
            se     = en && sclk_q;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt_q      <= sclkdiv;
            sclk_q     <= 1'b0;
            ext_q      <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            ext_q      <= sclk_in;
            ext_prev_q <= ext_q;
        end
    end

    assign sclk_int = sclk_q;

endmodule

// File: rtl/sport0_tx_serializer.sv
// SPORT0 transmit engine: TX buffer, framing FSM and MSB-first shifter onto DT.
module sport0_tx_serializer
    import sport_pkg::*;
(
    input  logic        DSPCLK,
    input  logic        RST_n,
    input  logic        TEN,
    input  logic        ISCLK,
    input  logic [15:0] SCLKDIV,
    input  logic        ITFS,
    input  logic        FSW,
    input  logic        INVTFS,
    input  logic        INVxSCLK,
    input  logic [4:0]  SLEN,
    input  logic        SCLK_in,
    input  logic        TFS_in,
    sport0_tx_serializer_if.slave bus,
    output logic        SCLK_out,
    output logic        SCLK_oe,
    output logic        TFS_out,
    output logic        TFS_oe,
    output logic        DT,
    output logic        DT_oe
);

    logic de, se, sclk_int;

    sport_sclk_gen u_sclk_gen (
        .clk      (DSPCLK),
        .rst_n    (RST_n),
        .en       (TEN),
        .isclk    (ISCLK),
        .sclkdiv  (SCLKDIV),
        .sclk_in  (SCLK_in),
        .de       (de),
        .se       (se),
        .sclk_int (sclk_int)
    );

    state_e              state_q, state_d;
    logic [TX_WIDTH-1:0] buf_q, buf_d, shreg_q, shreg_d;
    logic [4:0]          bitcnt_q, bitcnt_d, slen_eff;
    logic                full_q, full_d, last_q, last_d, tfs_q, tfs_d;
    logic                dt_q, dt_d, dt_oe_q, dt_oe_d, txreq_q, txreq_d, tuvf_q, tuvf_d;
    logic                load, tfs_ext;

    assign slen_eff = (SLEN < 5'(SLEN_MIN)) ? 5'(SLEN_MIN) : SLEN;
    assign tfs_ext  = TFS_in ^ INVTFS;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        tfs_d    = tfs_q;
        dt_d     = dt_q;
        dt_oe_d  = dt_oe_q;
        tuvf_d   = tuvf_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ITFS) begin
                    if (de && full_q) begin
                        load  = 1'b1;
                        tfs_d = 1'b1;
                        if (FSW) begin
                            dt_d     = buf_q[slen_eff];
                            dt_oe_d  = 1'b1;
                            bitcnt_d = slen_eff - 5'd1;
                            last_d   = 1'b0;
                            state_d  = SHIFT;
                        end else begin
                            bitcnt_d = slen_eff;
                            state_d  = SYNC;
                        end
                    end
                end else if (se && tfs_ext) begin
                    if (full_q) begin
                        load     = 1'b1;
                        bitcnt_d = slen_eff;
                        state_d  = SYNC;
                    end else begin
                        tuvf_d = 1'b1;
                    end
                end
            end
            SYNC: begin
                if (de) begin
                    dt_d     = shreg_q[bitcnt_q];
                    dt_oe_d  = 1'b1;
                    tfs_d    = 1'b0;
                    bitcnt_d = bitcnt_q - 5'd1;
                    last_d   = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (de) begin
                    tfs_d = 1'b0;
                    if (last_q) begin
                        // Alternate framing chains the next word with TFS on its MSB
                        if (ITFS && FSW && full_q) begin
                            load     = 1'b1;
                            tfs_d    = 1'b1;
                            dt_d     = buf_q[slen_eff];
                            bitcnt_d = slen_eff - 5'd1;
                            last_d   = 1'b0;
                        end else begin
                            dt_d    = 1'b0;
                            dt_oe_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        dt_d     = shreg_q[bitcnt_q];
                        bitcnt_d = bitcnt_q - 5'd1;
                        if (bitcnt_q == 5'd0) begin
                            last_d = 1'b1;
                            // Normal framing: TFS rides on the last bit, MSB follows via SYNC
                            if (ITFS && !FSW && full_q) begin
                                load     = 1'b1;
                                tfs_d    = 1'b1;
                                bitcnt_d = slen_eff;
                                state_d  = SYNC;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            shreg_d = buf_q;
        end
        full_d  = bus.TX_we ? 1'b1 : (load ? 1'b0 : full_q);
        buf_d   = bus.TX_we ? bus.TX_DATA : buf_q;
        txreq_d = load;
    end

    always_ff @(posedge DSPCLK) begin
        if (!RST_n || !TEN) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            shreg_q  <= '0;
            bitcnt_q <= 5'd0;
            full_q   <= 1'b0;
            last_q   <= 1'b0;
            tfs_q    <= 1'b0;
            dt_q     <= 1'b0;
            dt_oe_q  <= 1'b0;
            txreq_q  <= 1'b0;
            tuvf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            full_q   <= full_d;
            last_q   <= last_d;
            tfs_q    <= tfs_d;
            dt_q     <= dt_d;
            dt_oe_q  <= dt_oe_d;
            txreq_q  <= txreq_d;
            tuvf_q   <= tuvf_d;
        end
    end

    assign SCLK_out      = sclk_int ^ INVxSCLK;
    assign SCLK_oe       = ISCLK & TEN;
    assign TFS_out       = tfs_q ^ INVTFS;
    assign TFS_oe        = ITFS & TEN;
    assign DT            = dt_q;
    assign DT_oe         = dt_oe_q;
    assign bus.TBUF_FULL = full_q;
    assign bus.TXREQ     = txreq_q;
    assign bus.TUVF      = tuvf_q;

endmodule

// File: tb/tb_sport0_tx_serializer.sv
// Scoreboard bench for the SPORT0 transmitter: expected per-DE events queued, monitor pops them.
module tb_sport0_tx_serializer;

    logic        DSPCLK = 1'b0;
    logic        RST_n, TEN, ISCLK, ITFS, FSW, INVTFS, INVxSCLK, SCLK_in, TFS_in;
    logic [15:0] SCLKDIV;
    logic [4:0]  SLEN;
    logic        SCLK_out, SCLK_oe, TFS_out, TFS_oe, DT, DT_oe;

    sport0_tx_serializer_if bus ();

    sport0_tx_serializer dut (
        .DSPCLK   (DSPCLK),
        .RST_n    (RST_n),
        .TEN      (TEN),
        .ISCLK    (ISCLK),
        .SCLKDIV  (SCLKDIV),
        .ITFS     (ITFS),
        .FSW      (FSW),
        .INVTFS   (INVTFS),
        .INVxSCLK (INVxSCLK),
        .SLEN     (SLEN),
        .SCLK_in  (SCLK_in),
        .TFS_in   (TFS_in),
        .bus      (bus),
        .SCLK_out (SCLK_out),
        .SCLK_oe  (SCLK_oe),
        .TFS_out  (TFS_out),
        .TFS_oe   (TFS_oe),
        .DT       (DT),
        .DT_oe    (DT_oe)
    );

    always #5 DSPCLK = ~DSPCLK;

    // Event per SCLK rise: {DT_oe, DT, tfs active}
    logic [2:0] exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         txreq_cnt = 0;
    int         last_period = 0;
    bit         mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    initial begin : monitor
        logic       sp, sr, oep;
        logic [2:0] ev, e;
        int         cyc, last_rise;
        sp = 1'b0; oep = 1'b0; cyc = 0; last_rise = 0;
        forever begin
            @(negedge DSPCLK);
            cyc++;
            if (bus.TXREQ) txreq_cnt++;
            sr = SCLK_out ^ INVxSCLK;
            if (!TEN) oep = 1'b0;
            if (sr && !sp) begin
                last_period = cyc - last_rise;
                last_rise   = cyc;
                ev = {DT_oe, DT, TFS_out ^ INVTFS};
                if (mon_en && (DT_oe || ev[0] || oep)) begin
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_event: got %b, required no event", ev);
                    end else begin
                        e = exp_q.pop_front();
                        if (ev === e) n_pass++;
                        else $display("FAIL serial_event: got %b, required %b", ev, e);
                    end
                end
                oep = DT_oe;
            end
            sp = sr;
        end
    end

    task automatic push_word(input logic [31:0] d, input int slen, input bit lead,
                             input bit tfs_msb);
        if (lead) exp_q.push_back(3'b001);
        for (int i = slen; i >= 0; i--) exp_q.push_back({1'b1, d[i], (tfs_msb && i == slen)});
    endtask

    task automatic restart(input logic itfs, input logic fsw, input logic [4:0] slen);
        TEN = 1'b0;
        @(negedge DSPCLK);
        ITFS = itfs; FSW = fsw; SLEN = slen;
        txreq_cnt = 0;
        TEN = 1'b1;
    endtask

    task automatic write_word(input logic [31:0] d);
        bus.TX_DATA = d; bus.TX_we = 1'b1;
        @(negedge DSPCLK);
        bus.TX_we = 1'b0;
    endtask

    task automatic wait_txreq(input string name);
        int n = 0;
        while (!bus.TXREQ && n < 200) begin @(negedge DSPCLK); n++; end
        if (!bus.TXREQ) begin
            n_total++;
            $display("FAIL %s: TXREQ got 0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin @(negedge DSPCLK); n++; end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL %s: got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge DSPCLK);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        RST_n = 1'b0; TEN = 1'b0; ISCLK = 1'b1; SCLKDIV = 16'd1; ITFS = 1'b1; FSW = 1'b0;
        INVTFS = 1'b1; INVxSCLK = 1'b0; SLEN = 5'd7; SCLK_in = 1'b0; TFS_in = 1'b0;
        bus.TX_DATA = '0; bus.TX_we = 1'b0;
        repeat (3) @(negedge DSPCLK);
        check("reset_flags", {bus.TBUF_FULL, bus.TXREQ, bus.TUVF}, 0);
        check("reset_dt", {DT, DT_oe}, 0);
        check("reset_tfs_out", TFS_out, 1);
        check("reset_sclk_out", SCLK_out, 0);
        INVTFS = 1'b0;
        RST_n = 1'b1;

        // Normal framing, one word
        restart(1'b1, 1'b0, 5'd7);
        push_word(32'hA5, 7, 1'b1, 1'b0);
        exp_q.push_back(3'b000);
        write_word(32'hA5);
        check("tbuf_full_next_cycle", bus.TBUF_FULL, 1);
        drain("fsw0_word");
        check("fsw0_txreq_count", txreq_cnt, 1);
        check("sclk_period", last_period, 4);
        check("fsw0_idle_after", {DT_oe, bus.TBUF_FULL}, 0);

        // Alternate framing, second word written during the last bit
        restart(1'b1, 1'b1, 5'd7);
        push_word(32'hA5, 7, 1'b0, 1'b1);
        push_word(32'h3C, 7, 1'b0, 1'b1);
        exp_q.push_back(3'b000);
        write_word(32'hA5);
        wait_txreq("fsw1_first_load");
        repeat (29) @(negedge DSPCLK);
        write_word(32'h3C);
        drain("fsw1_chain");
        check("fsw1_txreq_count", txreq_cnt, 2);

        // External TFS with empty buffer underflows
        restart(1'b0, 1'b0, 5'd7);
        TFS_in = 1'b1;
        repeat (8) @(negedge DSPCLK);
        TFS_in = 1'b0;
        repeat (2) @(negedge DSPCLK);
        check("tuvf_set", bus.TUVF, 1);
        check("tuvf_dt_oe", DT_oe, 0);
        TEN = 1'b0;
        @(negedge DSPCLK);
        check("tuvf_cleared", bus.TUVF, 0);

        // External TFS with data: normal timing, no TFS driven
        restart(1'b0, 1'b1, 5'd7);
        push_word(32'h96, 7, 1'b0, 1'b0);
        exp_q.push_back(3'b000);
        write_word(32'h96);
        TFS_in = 1'b1;
        repeat (8) @(negedge DSPCLK);
        TFS_in = 1'b0;
        drain("ext_tfs_word");
        check("ext_txreq_count", txreq_cnt, 1);
        check("ext_no_tuvf", bus.TUVF, 0);

        // Full 32-bit word, inverted TFS and SCLK
        TEN = 1'b0; INVTFS = 1'b1; INVxSCLK = 1'b1;
        restart(1'b1, 1'b0, 5'd31);
        push_word(32'h8000_0001, 31, 1'b1, 1'b0);
        exp_q.push_back(3'b000);
        write_word(32'h8000_0001);
        drain("slen31_word");
        check("slen31_txreq_count", txreq_cnt, 1);
        check("inv_tfs_idle", TFS_out, 1);
        check("inv_sclk_idle", SCLK_out, 1);
        TEN = 1'b0; INVTFS = 1'b0; INVxSCLK = 1'b0;

        // Abort mid-word by TEN, then by RST_n
        mon_en = 1'b0;
        restart(1'b1, 1'b0, 5'd15);
        write_word(32'hF00F);
        wait_txreq("abort_ten_load");
        write_word(32'h1234);
        repeat (13) @(negedge DSPCLK);
        check("abort_ten_pre", {DT_oe, bus.TBUF_FULL}, 2'b11);
        TEN = 1'b0;
        @(negedge DSPCLK);
        check("abort_ten_post", {DT_oe, bus.TBUF_FULL, DT, TFS_out}, 0);
        TEN = 1'b1; txreq_cnt = 0;
        repeat (20) @(negedge DSPCLK);
        check("abort_ten_idle", {txreq_cnt[3:0], DT_oe}, 0);
        write_word(32'hBEEF);
        wait_txreq("abort_rst_load");
        write_word(32'h55);
        repeat (13) @(negedge DSPCLK);
        check("abort_rst_pre", {DT_oe, bus.TBUF_FULL}, 2'b11);
        RST_n = 1'b0;
        @(negedge DSPCLK);
        check("abort_rst_post", {DT_oe, bus.TBUF_FULL, DT, SCLK_out, bus.TXREQ}, 0);
        RST_n = 1'b1;
        TEN = 1'b0;
        @(negedge DSPCLK);
        mon_en = 1'b1;

        // Double write before load: last word wins, one TXREQ
        restart(1'b0, 1'b0, 5'd7);
        push_word(32'h22, 7, 1'b1, 1'b0);
        exp_q.push_back(3'b000);
        write_word(32'h11);
        write_word(32'h22);
        check("double_write_full", bus.TBUF_FULL, 1);
        ITFS = 1'b1;
        drain("double_write_word");
        check("double_write_txreq", txreq_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sport0_tx_serializer.md
# sport0_tx_serializer

SPORT0 transmit engine. Consumes the SPORT0 control fields (ISCLK, SCLKDIV, ITFS, FSW, INVTFS, INVxSCLK, SLEN) held in the SPORT0 control registers and serializes core-written words onto DT, MSB first. It generates the internal serial clock and transmit frame sync, or follows external ones. Sits between the DMD write path (TX buffer) and the SPORT0 pads.

## Interface
Parameters: none. Word width is fixed at 32, with the active length set by SLEN.
- DSPCLK  in  1  system clock; all logic on its rising edge
- RST_n  in  1  synchronous, active-low reset
- TEN  in  1  transmitter enable; 0 forces IDLE and clears the buffer
- ISCLK  in  1  1 = internal SCLK generated from SCLKDIV
- SCLKDIV  in  16  internal SCLK half-period minus 1, in DSPCLK cycles
- ITFS  in  1  1 = internal TFS
- FSW  in  1  0 = normal framing (TFS one SCLK before MSB), 1 = alternate (TFS with MSB)
- INVTFS  in  1  TFS active-low when 1
- INVxSCLK  in  1  invert SCLK_out
- SLEN  in  5  word length minus 1; legal values 1..31
- TX_DATA  in  32  right-justified transmit word
- TX_we  in  1  TX buffer write strobe
- SCLK_in  in  1  external SCLK, already synchronized to DSPCLK
- TFS_in  in  1  external TFS, already synchronized
- SCLK_out, SCLK_oe  out  1  serial clock; oe = ISCLK & TEN
- TFS_out, TFS_oe  out  1  frame sync; oe = ITFS & TEN
- DT, DT_oe  out  1  serial data and its enable
- TBUF_FULL  out  1  TX buffer holds an unsent word
- TXREQ  out  1  one-DSPCLK pulse when the buffer is moved into the shifter
- TUVF  out  1  sticky underflow flag, cleared by TEN = 0

## Operation
- Reset and TEN = 0 values:
  - all outputs 0, except TFS_out = INVTFS and SCLK_out = INVxSCLK
  - buffer empty; state IDLE; divider counter = SCLKDIV
- Internal SCLK:
  - Divider counts down from SCLKDIV. At 0 it reloads and toggles sclk_int.
  - SCLKDIV = 0 gives SCLK = DSPCLK/2.
  - Rising sclk_int is the driving edge (DE); falling is the sampling edge (SE).
- External SCLK: DE and SE are edge detects on registered SCLK_in.
- SCLK_out = sclk_int ^ INVxSCLK. sclk_int is held at 0 while ISCLK = 0.
- The TFS level is internal active-high. TFS_out = tfs ^ INVTFS, and TFS_in is XORed with INVTFS.
- TX buffer:
  - TX_we sets TBUF_FULL and latches TX_DATA.
  - A write while full overwrites the word; no flag is raised.
  - A write in the same cycle as a load wins: the buffer stays full with the new data.
- FSM states: IDLE, SYNC, SHIFT. bitcnt is 5 bits and counts down from SLEN.
- IDLE, internal TFS: at a DE with TBUF_FULL, load the shifter, clear TBUF_FULL and pulse TXREQ.
  - FSW = 0: drive tfs = 1 for one SCLK period, then go to SYNC.
  - FSW = 1: drive tfs = 1 and the MSB on the same DE, then go to SHIFT.
- IDLE, external TFS: at an SE with TFS_in active:
  - if TBUF_FULL, load and go to SYNC (normal timing always; FSW is ignored);
  - otherwise set TUVF and stay in IDLE.
- SYNC: at the next DE, drive the MSB (bit SLEN), set DT_oe = 1, go to SHIFT, tfs = 0.
- SHIFT:
  - At each DE, drive the next bit and decrement bitcnt.
  - When the last bit is driven with TBUF_FULL and ITFS = 1, the next word follows with no gap:
    - FSW = 0: tfs is asserted during the last bit and the MSB follows on the next DE;
    - FSW = 1: tfs is asserted with the next MSB.
  - Otherwise, at the DE after the last bit, DT_oe = 0, DT = 0 and the FSM returns to IDLE.
- TEN falling mid-word aborts on the next DSPCLK. There is no partial completion.
- SLEN is sampled at load only. Changes mid-word take effect on the next word.

## Timing
- TX_we in cycle n gives TBUF_FULL = 1 in cycle n+1.
- Shifter load to TXREQ: same DSPCLK as the load DE; the pulse is 1 cycle wide.
- DT and TFS_out change on the DSPCLK edge that registers a DE, so they are aligned to the SCLK rising edge.
- One word lasts SLEN+1 SCLK periods, plus one extra period of TFS lead in normal framing from IDLE.
- RST_n low in any state returns all reset values on the next DSPCLK edge.

## Structure
- Package sport_pkg:
  - state enum {IDLE, SYNC, SHIFT}
  - constant TX_WIDTH = 32
  - SLEN_MIN = 1
- Sub-module sport_sclk_gen:
  - divider plus internal/external select
  - outputs DE/SE strobes and sclk_int
  - shared later with the receiver.

## Test plan
- ISCLK = 1, SCLKDIV = 1, ITFS = 1, FSW = 0, SLEN = 7; write 0xA5 -> one TFS period, then DT = 1,0,1,0,0,1,0,1 on successive DEs; SCLK period = 4 DSPCLK; one TXREQ pulse.
- Same setup with FSW = 1, then write 0x3C again during the last bit of the first word -> TFS coincides with each MSB; 16 contiguous bits with no gap; 2 TXREQ pulses.
- ITFS = 0, external TFS pulse with the buffer empty -> TUVF = 1; DT_oe stays 0; TEN = 0 clears TUVF.
- SLEN = 31, data 0x8000_0001 -> 32 bits, first and last = 1; bitcnt wraps without error.
- TEN dropped at bit 3 of a 16-bit word -> next DSPCLK: DT_oe = 0, TBUF_FULL = 0, FSM in IDLE; RST_n mid-word gives the same result.
- Write twice before a load (0x11 then 0x22) -> 0x22 is transmitted; exactly one TXREQ.
